iic_slave_rx: RTL and testbench



---
 rtl/iic_slave_rx_if.sv | 11 +
 rtl/iic_slave_rx.sv | 215 +++++++++++++++++++++
 tb/tb_iic_slave_rx.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/iic_slave_rx_if.sv
// Register-side handshake of the I2C write receiver: own address in, received word and status out.
interface iic_slave_rx_if;
    logic [6:0]  i_dev_addr;
    logic [31:0] o_rx_data;
    logic [3:0]  o_rx_length;
    logic        o_rx_valid;
    logic        o_busy;

    modport slave  (input  i_dev_addr, output o_rx_data, o_rx_length, o_rx_valid, o_busy);
    modport master (output i_dev_addr, input  o_rx_data, o_rx_length, o_rx_valid, o_busy);
endinterface

// File: rtl/iic_slave_rx.sv
// I2C target write receiver: matches a 7-bit address, ACKs up to 4 data bytes and strobes the word out.
// Optional SCL/SDA glitch filter enabled by defining IIC_SLAVE_GLITCH_FILTER_EN (depth C_FILT_LEN).
module iic_slave_rx #(
    parameter int unsigned C_FILT_LEN = 4
) (
    input  logic          i_clk_50m,
    input  logic          i_rst,
    input  logic          i_iic_scl,
    inout  wire           io_iic_sda,
    iic_slave_rx_if.slave rx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    if (C_FILT_LEN < 2 || C_FILT_LEN > 15) begin : g_bad_filt_len
        $error("iic_slave_rx: C_FILT_LEN must be in 2..15");
    end

    // Bit 1 carries SCL, bit 0 carries SDA; an idle bus reads high on both.
    logic [1:0] line_meta;
    logic [1:0] line_sync;
    logic [1:0] line_clean;
    logic [1:0] line_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            line_meta <= 2'b11;
            line_sync <= 2'b11;
        end else begin
            line_meta <= {i_iic_scl, io_iic_sda};
            line_sync <= line_meta;
        end
    end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    logic [3:0] filt_cnt [2];

    // A line only changes after C_FILT_LEN consecutive samples disagree with its filtered value.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            line_clean  <= 2'b11;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (line_sync[i] == line_clean[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == 4'(C_FILT_LEN - 1)) begin
                    line_clean[i] <= line_sync[i];
                    filt_cnt[i]   <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 4'd1;
                end
            end
        end
    end
`else
    assign line_clean = line_sync;
`endif

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            line_d <= 2'b11;
        end else begin
            line_d <= line_clean;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  =  line_clean[1] & ~line_d[1];
    assign scl_fall  = ~line_clean[1] &  line_d[1];
    assign start_det =  line_clean[1] &  line_d[1] &  line_d[0] & ~line_clean[0];
    assign stop_det  =  line_clean[1] &  line_d[1] & ~line_d[0] &  line_clean[0];

    state_t      state, state_nxt;
    logic        sda_oe, sda_oe_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [2:0]  byte_cnt, byte_cnt_nxt;
    logic [6:0]  byte_sr, byte_sr_nxt;
    logic [31:0] word_sr, word_sr_nxt;
    logic        busy, busy_nxt;
    logic [31:0] rx_data_q, rx_data_nxt;
    logic [3:0]  rx_len_q, rx_len_nxt;
    logic        rx_valid_q, rx_valid_nxt;
    logic [7:0]  rx_byte;

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state      <= S_IDLE;
            sda_oe     <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            byte_sr    <= '0;
            word_sr    <= '0;
            busy       <= 1'b0;
            rx_data_q  <= '0;
            rx_len_q   <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            sda_oe     <= sda_oe_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_cnt   <= byte_cnt_nxt;
            byte_sr    <= byte_sr_nxt;
            word_sr    <= word_sr_nxt;
            busy       <= busy_nxt;
            rx_data_q  <= rx_data_nxt;
            rx_len_q   <= rx_len_nxt;
            rx_valid_q <= rx_valid_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        sda_oe_nxt   = sda_oe;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        byte_sr_nxt  = byte_sr;
        word_sr_nxt  = word_sr;
        busy_nxt     = busy;
        rx_data_nxt  = rx_data_q;
        rx_len_nxt   = rx_len_q;
        rx_valid_nxt = 1'b0;
        rx_byte      = {byte_sr, line_clean[0]};

        if (start_det || stop_det) begin
            // Bus framing wins over any bit-level activity seen in the same cycle.
            if (busy && byte_cnt != 3'd0) begin
                rx_data_nxt  = word_sr;
                rx_len_nxt   = {1'b0, byte_cnt};
                rx_valid_nxt = 1'b1;
            end
            sda_oe_nxt   = 1'b0;
            bit_cnt_nxt  = '0;
            byte_cnt_nxt = '0;
            byte_sr_nxt  = '0;
            word_sr_nxt  = '0;
            busy_nxt     = 1'b0;
            state_nxt    = start_det ? S_ADDR : S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_IGNORE: begin
                    sda_oe_nxt = 1'b0;
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        byte_sr_nxt = rx_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
                            if (rx_byte == {rx.i_dev_addr, 1'b0}) begin
                                busy_nxt  = 1'b1;
                                state_nxt = S_ADDR_ACK;
                            end else begin
                                state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    // First fall opens the ACK window, the second (end of 9th clock) closes it.
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        byte_sr_nxt = rx_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
                            if (byte_cnt < 3'd4) begin
                                word_sr_nxt  = {word_sr[23:0], rx_byte};
                                byte_cnt_nxt = byte_cnt + 3'd1;
                                state_nxt    = S_DATA_ACK;
                            end else begin
                                state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                default: begin
                    sda_oe_nxt = 1'b0;
                    state_nxt  = S_IDLE;
                end
            endcase
        end
    end

    // Open-drain: the line is only ever pulled low, never driven high.
    assign io_iic_sda     = sda_oe ? 1'b0 : 1'bz;
    assign rx.o_rx_data   = rx_data_q;
    assign rx.o_rx_length = rx_len_q;
    assign rx.o_rx_valid  = rx_valid_q;
    assign rx.o_busy      = busy;

endmodule

// File: tb/tb_iic_slave_rx.sv
// Directed bench for iic_slave_rx: an I2C write master on an open-drain SDA with a pull-up.
module tb_iic_slave_rx;

    localparam int Q = 10;  // quarter of an SCL period, in system clocks

    logic i_clk_50m = 1'b0;
    logic i_rst     = 1'b1;
    logic scl_drv   = 1'b1;
    logic sda_low   = 1'b0;
    wire  sda_bus;

    int checks   = 0;
    int failures = 0;

    iic_slave_rx_if rx_if ();

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    iic_slave_rx #(.C_FILT_LEN(4)) dut (
        .i_clk_50m  (i_clk_50m),
        .i_rst      (i_rst),
        .i_iic_scl  (scl_drv),
        .io_iic_sda (sda_bus),
        .rx         (rx_if.slave)
    );

    always #10 i_clk_50m = ~i_clk_50m;

    // Strobe recorder: last four captured words and the longest run of o_rx_valid.
    int          strobe_cnt = 0;
    int          run_len    = 0;
    int          max_run    = 0;
    logic [31:0] cap_data [4];
    logic [3:0]  cap_len  [4];

    always @(negedge i_clk_50m) begin
        if (rx_if.o_rx_valid === 1'b1) begin
            cap_data[strobe_cnt % 4] = rx_if.o_rx_data;
            cap_len[strobe_cnt % 4]  = rx_if.o_rx_length;
            strobe_cnt = strobe_cnt + 1;
            run_len    = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk_50m);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic bus_start();
        if (!scl_drv) begin
            tick(Q); sda_low = 1'b0; tick(Q); scl_drv = 1'b1; tick(2 * Q);
        end
        sda_low = 1'b1; tick(2 * Q); scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        tick(Q); sda_low = 1'b1; tick(Q); scl_drv = 1'b1; tick(2 * Q);
        sda_low = 1'b0; tick(4 * Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        tick(Q); sda_low = !b; tick(Q); scl_drv = 1'b1; tick(Q);
        if (glitch) begin
            scl_drv = 1'b0; tick(2); scl_drv = 1'b1; tick(Q - 2);
        end else begin
            tick(Q);
        end
        scl_drv = 1'b0;
    endtask

    task automatic send_bits8(input logic [7:0] b, input int glitch_at);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_at);
    endtask

    task automatic ack_clock(output logic acked);
        tick(Q); sda_low = 1'b0; tick(Q); scl_drv = 1'b1; tick(Q);
        acked = (sda_bus === 1'b0);
        tick(Q); scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        send_bits8(b, -1);
        ack_clock(acked);
    endtask

    initial begin
        logic ack;
        int   base;

        rx_if.i_dev_addr = 7'h50;
        tick(5);
        i_rst = 1'b0;
        tick(5);

        check("reset rx_data",   rx_if.o_rx_data, 32'd0);
        check("reset rx_length", 32'(rx_if.o_rx_length), 32'd0);
        check("reset rx_valid",  32'(rx_if.o_rx_valid), 32'd0);
        check("reset busy",      32'(rx_if.o_busy), 32'd0);
        check("reset sda",       32'(sda_bus), 32'd1);

        // Basic two-byte write.
        base = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t1 addr ack", 32'(ack), 32'd1);
        check("t1 busy", 32'(rx_if.o_busy), 32'd1);
        send_byte(8'hA5, ack); check("t1 byte1 ack", 32'(ack), 32'd1);
        send_byte(8'h3C, ack); check("t1 byte2 ack", 32'(ack), 32'd1);
        bus_stop();
        check("t1 strobes", 32'(strobe_cnt - base), 32'd1);
        check("t1 data",    cap_data[base % 4], 32'h0000A53C);
        check("t1 length",  32'(cap_len[base % 4]), 32'd2);
        check("t1 busy end", 32'(rx_if.o_busy), 32'd0);

        // Address only, then STOP: no strobe, outputs hold.
        base = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t2 addr ack", 32'(ack), 32'd1);
        bus_stop();
        check("t2 strobes", 32'(strobe_cnt - base), 32'd0);
        check("t2 data held", rx_if.o_rx_data, 32'h0000A53C);

        // Wrong address: NACK, stay idle.
        base = strobe_cnt;
        bus_start();
        send_byte(8'hA2, ack); check("t3 addr nack", 32'(ack), 32'd0);
        check("t3 busy", 32'(rx_if.o_busy), 32'd0);
        bus_stop();
        check("t3 strobes", 32'(strobe_cnt - base), 32'd0);

        // Five data bytes: the fifth is refused.
        base = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t4 addr ack", 32'(ack), 32'd1);
        send_byte(8'h11, ack); check("t4 b1 ack", 32'(ack), 32'd1);
        send_byte(8'h22, ack); check("t4 b2 ack", 32'(ack), 32'd1);
        send_byte(8'h33, ack); check("t4 b3 ack", 32'(ack), 32'd1);
        send_byte(8'h44, ack); check("t4 b4 ack", 32'(ack), 32'd1);
        send_byte(8'h55, ack); check("t4 b5 nack", 32'(ack), 32'd0);
        bus_stop();
        check("t4 strobes", 32'(strobe_cnt - base), 32'd1);
        check("t4 data",    cap_data[base % 4], 32'h11223344);
        check("t4 length",  32'(cap_len[base % 4]), 32'd4);

        // Repeated START closes the first word.
        base = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t5 addr1 ack", 32'(ack), 32'd1);
        send_byte(8'hDE, ack); check("t5 de ack", 32'(ack), 32'd1);
        bus_start();
        send_byte(8'hA0, ack); check("t5 addr2 ack", 32'(ack), 32'd1);
        send_byte(8'hBE, ack); check("t5 be ack", 32'(ack), 32'd1);
        bus_stop();
        check("t5 strobes", 32'(strobe_cnt - base), 32'd2);
        check("t5 data1",   cap_data[base % 4], 32'h000000DE);
        check("t5 length1", 32'(cap_len[base % 4]), 32'd1);
        check("t5 data2",   cap_data[(base + 1) % 4], 32'h000000BE);
        check("t5 length2", 32'(cap_len[(base + 1) % 4]), 32'd1);

        // Reset pulse during the ACK of data byte 2.
        base = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t6 addr ack", 32'(ack), 32'd1);
        send_byte(8'h01, ack); check("t6 b1 ack", 32'(ack), 32'd1);
        send_bits8(8'h02, -1);
        tick(Q); sda_low = 1'b0; tick(Q);
        check("t6 ack driven", 32'(sda_bus), 32'd0);
        i_rst = 1'b1; tick(1); i_rst = 1'b0; tick(1);
        check("t6 sda released", 32'(sda_bus), 32'd1);
        scl_drv = 1'b1; tick(2 * Q); scl_drv = 1'b0;
        bus_stop();
        check("t6 strobes", 32'(strobe_cnt - base), 32'd0);
        check("t6 busy", 32'(rx_if.o_busy), 32'd0);
        base = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t6 re addr ack", 32'(ack), 32'd1);
        send_byte(8'hCA, ack); check("t6 re b1 ack", 32'(ack), 32'd1);
        send_byte(8'hFE, ack); check("t6 re b2 ack", 32'(ack), 32'd1);
        bus_stop();
        check("t6 re strobes", 32'(strobe_cnt - base), 32'd1);
        check("t6 re data",    cap_data[base % 4], 32'h0000CAFE);
        check("t6 re length",  32'(cap_len[base % 4]), 32'd2);

        // Two-clock SCL low glitch inside data bit 4 of 0x5A.
        base = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t7 addr ack", 32'(ack), 32'd1);
        send_bits8(8'h5A, 4);
        ack_clock(ack);
        bus_stop();
        check("t7 strobes", 32'(strobe_cnt - base), 32'd1);
`ifdef IIC_SLAVE_GLITCH_FILTER_EN
        check("t7 glitch ack",  32'(ack), 32'd1);
        check("t7 glitch data", cap_data[base % 4], 32'h0000005A);
`else
        check("t7 glitch ack",  32'(ack), 32'd0);
        check("t7 glitch data", cap_data[base % 4], 32'h0000005D);
`endif
        check("t7 length", 32'(cap_len[base % 4]), 32'd1);

        check("valid one cycle", 32'(max_run), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
